// File: rtl/branch_resolve_unit.sv
// Resolves the Decode-stage gshare prediction in Execute, raises a held redirect to Fetch on a
// mispredict, drives the Memory-stage predictor update bus and counts retired branches/mispredicts.
module branch_resolve_unit #(
    parameter int          CNT_WIDTH    = 32,
    parameter logic [31:0] DSLOT_OFFSET = 32'd8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stallE,
    input  logic                 flushE,
    input  logic                 stallM,
    input  logic                 flushM,
    input  logic                 branchD,
    input  logic                 pred_takeD,
    input  logic [31:0]          pcD,
    input  logic [31:0]          targetD,
    input  logic                 actual_takeE,
    input  logic                 redirect_ready,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    output logic                 mispredE,
    output logic                 branchM,
    output logic                 actual_takeM,
    output logic                 pred_wrong,
    output logic [31:0]          pcM,
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic [CNT_WIDTH-1:0] mispred_cnt
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t               state_reg, state_next;
    logic [31:0]          redirect_pc_reg, redirect_pc_next;

    logic                 branch_e_reg;
    logic                 pred_take_e_reg;
    logic [31:0]          pc_e_reg;
    logic [31:0]          target_e_reg;

    logic                 branch_m_reg;
    logic                 actual_take_m_reg;
    logic                 pred_wrong_reg;
    logic [31:0]          pc_m_reg;

    logic [CNT_WIDTH-1:0] branch_cnt_reg;
    logic [CNT_WIDTH-1:0] mispred_cnt_reg;

    logic                 mis;
    logic                 dir_wrong;
    logic                 retire;

    // D->E pipeline register
    always_ff @(posedge clk) begin
        if (!rst || flushE) begin
            branch_e_reg    <= 1'b0;
            pred_take_e_reg <= 1'b0;
            pc_e_reg        <= '0;
            target_e_reg    <= '0;
        end else if (!stallE) begin
            branch_e_reg    <= branchD;
            pred_take_e_reg <= pred_takeD;
            pc_e_reg        <= pcD;
            target_e_reg    <= targetD;
        end
    end

    assign dir_wrong = pred_take_e_reg ^ actual_takeE;
    // While a redirect is pending, everything in E is wrong-path and must not raise another.
    assign mis       = branch_e_reg & ~stallE & dir_wrong & (state_reg == IDLE);
    assign mispredE  = mis;

    // E->M pipeline register; pred_wrong tracks the true outcome regardless of redirect suppression
    always_ff @(posedge clk) begin
        if (!rst || flushM) begin
            branch_m_reg      <= 1'b0;
            actual_take_m_reg <= 1'b0;
            pred_wrong_reg    <= 1'b0;
            pc_m_reg          <= '0;
        end else if (!stallM) begin
            branch_m_reg      <= branch_e_reg & ~stallE;
            actual_take_m_reg <= actual_takeE;
            pred_wrong_reg    <= branch_e_reg & dir_wrong;
            pc_m_reg          <= pc_e_reg;
        end
    end

    always_comb begin
        state_next       = state_reg;
        redirect_pc_next = redirect_pc_reg;
        case (state_reg)
            IDLE: begin
                if (mis) begin
                    state_next       = PENDING;
                    redirect_pc_next = actual_takeE ? target_e_reg : (pc_e_reg + DSLOT_OFFSET);
                end
            end
            PENDING: begin
                if (redirect_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg       <= IDLE;
            redirect_pc_reg <= '0;
        end else begin
            state_reg       <= state_next;
            redirect_pc_reg <= redirect_pc_next;
        end
    end

    assign retire = branch_m_reg & ~stallM & ~flushM;

    // Retire statistics saturate rather than wrap
    always_ff @(posedge clk) begin
        if (!rst) begin
            branch_cnt_reg  <= '0;
            mispred_cnt_reg <= '0;
        end else if (retire) begin
            if (branch_cnt_reg != CNT_MAX) begin
                branch_cnt_reg <= branch_cnt_reg + CNT_ONE;
            end
            if (pred_wrong_reg && (mispred_cnt_reg != CNT_MAX)) begin
                mispred_cnt_reg <= mispred_cnt_reg + CNT_ONE;
            end
        end
    end

    assign redirect_valid = (state_reg == PENDING);
    assign redirect_pc    = redirect_pc_reg;
    assign branchM        = branch_m_reg;
    assign actual_takeM   = actual_take_m_reg;
    assign pred_wrong     = pred_wrong_reg;
    assign pcM            = pc_m_reg;
    assign branch_cnt     = branch_cnt_reg;
    assign mispred_cnt    = mispred_cnt_reg;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench: a slot-level model of the branch path pushes expectations; a negedge monitor
// pops and compares them whenever the DUT shows a cycle, a retirement or an accepted redirect.
module tb_branch_resolve_unit;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst, stallE, flushE, stallM, flushM;
    logic             branchD, pred_takeD, actual_takeE, redirect_ready;
    logic [31:0]      pcD, targetD;
    logic             redirect_valid, mispredE, branchM, actual_takeM, pred_wrong;
    logic [31:0]      redirect_pc, pcM;
    logic [CNT_W-1:0] branch_cnt, mispred_cnt;

    always #5 clk = ~clk;

    branch_resolve_unit #(.CNT_WIDTH(CNT_W), .DSLOT_OFFSET(32'd8)) dut (
        .clk(clk), .rst(rst), .stallE(stallE), .flushE(flushE), .stallM(stallM), .flushM(flushM),
        .branchD(branchD), .pred_takeD(pred_takeD), .pcD(pcD), .targetD(targetD),
        .actual_takeE(actual_takeE), .redirect_ready(redirect_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .mispredE(mispredE),
        .branchM(branchM), .actual_takeM(actual_takeM), .pred_wrong(pred_wrong), .pcM(pcM),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    typedef struct { bit valid; bit pred; logic [31:0] pc; logic [31:0] target; } e_rec_t;
    typedef struct { bit valid; bit actual; bit wrong; logic [31:0] pc; } m_rec_t;
    typedef struct { bit mis; bit rv; bit bm; } cyc_t;
    typedef struct { bit actual; bit wrong; logic [31:0] pc; int bc; int mc; } ret_t;

    cyc_t        cyc_q[$];
    ret_t        ret_q[$];
    logic [31:0] redir_q[$];

    e_rec_t me;
    m_rec_t mm;
    bit     m_pend;
    int     m_bc, m_mc;
    int     total  = 0;
    int     passed = 0;
    bit     armed  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic miss(input string name);
        total++;
        $display("FAIL %s: got unexpected DUT event, expected none queued", name);
    endtask

    function automatic void model_reset();
        me     = '{default: 0};
        mm     = '{default: 0};
        m_pend = 1'b0;
        m_bc   = 0;
        m_mc   = 0;
        redir_q.delete();
        ret_q.delete();
    endfunction

    // Evaluate one cycle of the reference model on the current inputs, then let the clock tick.
    task automatic cycle();
        cyc_t        c;
        ret_t        r;
        e_rec_t      ne;
        m_rec_t      nm;
        bit          mis;
        logic [31:0] fall;
        mis   = me.valid && !stallE && (me.pred != actual_takeE) && !m_pend;
        c.mis = mis;
        c.rv  = m_pend;
        c.bm  = mm.valid;
        cyc_q.push_back(c);
        if (rst) begin
            if (mm.valid && !stallM && !flushM) begin
                r = '{actual: mm.actual, wrong: mm.wrong, pc: mm.pc, bc: m_bc, mc: m_mc};
                ret_q.push_back(r);
                if (m_bc < CNT_MAX) m_bc++;
                if (mm.wrong && m_mc < CNT_MAX) m_mc++;
            end
            if (mis) begin
                fall = 32'((64'(me.pc) + 64'd8) % 64'h1_0000_0000);
                redir_q.push_back(actual_takeE ? me.target : fall);
            end
            if (flushM) nm = '{default: 0};
            else if (!stallM)
                nm = '{valid: me.valid && !stallE, actual: actual_takeE,
                       wrong: me.valid && (me.pred != actual_takeE), pc: me.pc};
            else nm = mm;
            if (flushE) ne = '{default: 0};
            else if (!stallE) ne = '{valid: branchD, pred: pred_takeD, pc: pcD, target: targetD};
            else ne = me;
            if (m_pend) m_pend = !redirect_ready;
            else        m_pend = mis;
            me = ne;
            mm = nm;
        end else begin
            model_reset();
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        cyc_t c;
        ret_t r;
        if (armed) begin
            if (cyc_q.size() == 0) miss("cycle_underflow");
            else begin
                c = cyc_q.pop_front();
                chk("mispredE", mispredE, c.mis);
                chk("redirect_valid", redirect_valid, c.rv);
                chk("branchM", branchM, c.bm);
            end
            if (redirect_valid && redir_q.size() > 0) chk("redirect_pc", redirect_pc, redir_q[0]);
            if (rst && redirect_valid && redirect_ready) begin
                if (redir_q.size() == 0) miss("redirect_accept");
                else void'(redir_q.pop_front());
            end
            if (rst && branchM && !stallM && !flushM) begin
                if (ret_q.size() == 0) miss("retire");
                else begin
                    r = ret_q.pop_front();
                    chk("pcM", pcM, r.pc);
                    chk("actual_takeM", actual_takeM, r.actual);
                    chk("pred_wrong", pred_wrong, r.wrong);
                    chk("branch_cnt", branch_cnt, r.bc);
                    chk("mispred_cnt", mispred_cnt, r.mc);
                end
            end
        end
    end

    task automatic idle();
        rst = 1'b1; stallE = 1'b0; flushE = 1'b0; stallM = 1'b0; flushM = 1'b0;
        branchD = 1'b0; pred_takeD = 1'b0; pcD = '0; targetD = '0;
        actual_takeE = 1'b0; redirect_ready = 1'b0;
    endtask

    task automatic rand_inputs();
        rst            = ($urandom_range(99) >= 1);
        stallE         = ($urandom_range(99) < 15);
        flushE         = ($urandom_range(99) < 10);
        stallM         = ($urandom_range(99) < 15);
        flushM         = ($urandom_range(99) < 10);
        branchD        = ($urandom_range(99) < 60);
        pred_takeD     = 1'($urandom_range(1));
        pcD            = ($urandom_range(99) < 10) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
        targetD        = $urandom() & 32'hFFFF_FFFC;
        actual_takeE   = 1'($urandom_range(1));
        redirect_ready = ($urandom_range(99) < 50);
    endtask

    task automatic load_d(input bit pred, input logic [31:0] pc, input logic [31:0] tgt);
        branchD = 1'b1; pred_takeD = pred; pcD = pc; targetD = tgt;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        branchD = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        armed = 1'b1;

        // Reset held two cycles under random traffic
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            rst = 1'b0;
            branchD = 1'b1;
            cycle();
        end
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_branchM", branchM, 0);
        chk("rst_pcM", pcM, 0);
        chk("rst_pred_wrong", pred_wrong, 0);
        chk("rst_branch_cnt", branch_cnt, 0);
        chk("rst_mispred_cnt", mispred_cnt, 0);
        idle(); cycle();
        chk("rel_branch_cnt", branch_cnt, 0);

        // Correct prediction
        idle(); load_d(1'b1, 32'h0000_1000, 32'h0000_3000); cycle();
        idle(); actual_takeE = 1'b1; cycle();
        idle(); cycle();
        chk("t2_branch_cnt", branch_cnt, 1);
        chk("t2_mispred_cnt", mispred_cnt, 0);

        // Not-taken mispredict, accepted immediately
        idle(); load_d(1'b0, 32'h0000_1000, 32'h0000_2000); cycle();
        idle(); actual_takeE = 1'b1; redirect_ready = 1'b1; cycle();
        chk("t3_redirect_pc", redirect_pc, 32'h0000_2000);
        idle(); redirect_ready = 1'b1; cycle();
        chk("t3_redirect_valid", redirect_valid, 0);
        chk("t3_branch_cnt", branch_cnt, 2);
        chk("t3_mispred_cnt", mispred_cnt, 1);

        // Taken mispredict at top of address space, backpressured, with a suppressed follower
        idle(); load_d(1'b1, 32'hFFFF_FFFC, 32'h0000_5000); cycle();
        idle(); load_d(1'b1, 32'h0000_0100, 32'h0000_0200); cycle();
        chk("t4_redirect_pc", redirect_pc, 32'h0000_0004);
        idle(); cycle();
        idle(); cycle();
        idle(); cycle();
        chk("t4_held_valid", redirect_valid, 1);
        idle(); redirect_ready = 1'b1; cycle();
        chk("t4_redirect_valid", redirect_valid, 0);
        chk("t4_branch_cnt", branch_cnt, 4);
        chk("t4_mispred_cnt", mispred_cnt, 3);

        // Flush beats stall in E; stallM holds M; flushM drops a branch
        idle(); load_d(1'b0, 32'h0000_0040, 32'h0000_0080); cycle();
        idle(); stallE = 1'b1; flushE = 1'b1; actual_takeE = 1'b1; cycle();
        idle(); cycle();
        chk("t5_flushE_branchM", branchM, 0);
        idle(); load_d(1'b1, 32'h0000_0060, 32'h0000_0090); cycle();
        idle(); actual_takeE = 1'b1; cycle();
        idle(); stallM = 1'b1; cycle(); cycle();
        chk("t5_stallM_branchM", branchM, 1);
        chk("t5_stallM_pcM", pcM, 32'h0000_0060);
        chk("t5_stallM_cnt", branch_cnt, 4);
        idle(); cycle();
        chk("t5_retire_cnt", branch_cnt, 5);
        idle(); load_d(1'b1, 32'h0000_0070, 32'h0000_00A0); cycle();
        idle(); actual_takeE = 1'b1; flushM = 1'b1; cycle();
        chk("t5_flushM_branchM", branchM, 0);
        idle(); cycle();
        chk("t5_flushM_cnt", branch_cnt, 5);

        // Reset while a redirect is pending
        idle(); load_d(1'b0, 32'h0000_0010, 32'h0000_0020); cycle();
        idle(); actual_takeE = 1'b1; cycle();
        chk("t6_pending", redirect_valid, 1);
        idle(); rst = 1'b0; redirect_ready = 1'b1; cycle();
        chk("t6_rst_valid", redirect_valid, 0);
        chk("t6_rst_branchM", branchM, 0);
        chk("t6_rst_cnt", branch_cnt, 0);

        // Saturation: more than 2^CNT_W retired mispredicts
        for (int i = 0; i < 22; i++) begin
            idle(); load_d(1'b0, 32'h0000_4000 + 32'(i * 4), 32'h0000_8000);
            actual_takeE = 1'b1; redirect_ready = 1'b1; cycle();
        end
        idle(); redirect_ready = 1'b1; cycle(); cycle(); cycle();
        chk("sat_branch_cnt", branch_cnt, CNT_MAX);
        chk("sat_mispred_cnt", mispred_cnt, CNT_MAX);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            cycle();
        end

        idle(); redirect_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        chk("end_redir_q", redir_q.size(), 0);
        chk("end_ret_q", ret_q.size(), 0);
        chk("end_branch_cnt", branch_cnt, m_bc);
        chk("end_mispred_cnt", mispred_cnt, m_mc);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Consumer end of the gshare prediction path. It carries the Decode-stage direction prediction (pred_takeD) down the pipe and resolves it against the actual outcome in Execute. On a mispredict it raises a held redirect request to Fetch. It also supplies the Memory-stage update bus the predictor consumes (branchM, actual_takeM, pred_wrong, pcM) and keeps retire-time branch/mispredict statistics.

Parameters:
CNT_WIDTH, 32, width of statistics counters (saturating)
DSLOT_OFFSET, 8, fall-through offset from branch PC (MIPS delay slot: pc+8)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low (rst==0 resets)
stallE  in  1  hold D->E register
flushE  in  1  clear D->E register
stallM  in  1  hold E->M register
flushM  in  1  clear E->M register
branchD  in  1  Decode holds a conditional branch
pred_takeD  in  1  predictor direction for branch in D
pcD  in  32  PC of branch in D
targetD  in  32  taken target computed in D
actual_takeE  in  1  resolved direction from Execute comparator
redirect_ready  in  1  Fetch accepts redirect this cycle (~stallF)
redirect_valid  out  1  redirect request pending
redirect_pc  out  32  correct next fetch PC
mispredE  out  1  one-cycle pulse: mispredict detected in E (flush request to hazard unit)
branchM  out  1  branch in Memory stage
actual_takeM  out  1  resolved direction, M stage
pred_wrong  out  1  M-stage branch was mispredicted
pcM  out  32  PC of M-stage branch
branch_cnt  out  CNT_WIDTH  retired branches
mispred_cnt  out  CNT_WIDTH  retired mispredicted branches

Behaviour:
- Reset (rst==0 at posedge): all pipeline regs, outputs, counters = 0; FSM = IDLE. Reset overrides every other input, including mid-redirect.
- D->E reg {branchE, pred_takeE, pcE, targetE}:
  - flushE: clear to 0 (flush wins over stall).
  - else if ~stallE: load {branchD, pred_takeD, pcD, targetD}.
  - else hold.
- Mispredict detect (combinational on E contents): mis = branchE & ~stallE & (pred_takeE ^ actual_takeE) & (state==IDLE).
  - mispredE = mis. It is evaluated on current E contents even if flushE is asserted in the same cycle.
- E->M reg {branchM, actual_takeM, pred_wrong, pcM}:
  - flushM: clear (wins over stall).
  - else if ~stallM: load {branchE & ~stallE, actual_takeE, branchE & (pred_takeE ^ actual_takeE), pcE}.
  - else hold.
  - pred_wrong in M reflects the true mispredict, independent of FSM suppression.
  - Latency E->M = 1 cycle.
- Redirect FSM, states IDLE and PENDING:
  - IDLE: if mis, capture redirect_pc = actual_takeE ? targetE : pcE + DSLOT_OFFSET (32-bit wrap, no carry out). Then go to PENDING next cycle. redirect_valid=1 from that next cycle.
  - PENDING: redirect_valid=1 and redirect_pc stable. If redirect_ready, return to IDLE next cycle (redirect_valid=0 then). Otherwise hold indefinitely.
  - New mispredicts are suppressed while PENDING: they are younger, wrong-path instructions.
  - redirect_ready in IDLE is ignored.
  - Minimum mis-to-accept-to-IDLE turnaround: mis cycle N, valid N+1, accepted N+1, IDLE N+2. A new mis may be detected in N+2.
- Counters, updated when branchM & ~stallM & ~flushM:
  - branch_cnt += 1.
  - mispred_cnt += pred_wrong.
  - Both saturate at all-ones; there is no wrap.
- Outputs are registered except mispredE.

Test Plan:
- Reset: hold rst=0 for 2 cycles with branchD=1 and other inputs random -> all outputs 0, state IDLE; release, counters remain 0.
- Correct prediction: branchD=1, pred_takeD=1, pcD=0x0000_1000, then actual_takeE=1 -> mispredE never 1, redirect_valid=0; next cycle branchM=1, actual_takeM=1, pred_wrong=0, pcM=0x1000; branch_cnt=1, mispred_cnt=0.
- Not-taken mispredict: pred_takeD=0, targetD=0x2000, pcD=0x1000, actual_takeE=1, redirect_ready=1 -> mispredE pulse 1 cycle; redirect_valid=1 for exactly 1 cycle with redirect_pc=0x2000; pred_wrong=1 in M; mispred_cnt=1.
- Taken mispredict with backpressure: pred_takeD=1, pcD=0xFFFF_FFFC, actual_takeE=0, redirect_ready=0 for 3 cycles then 1 -> redirect_pc=0x0000_0004 (wrap), redirect_valid high for 4 cycles; a second mispredicting branch in E during PENDING gives mispredE=0.
- Stall/flush precedence: stallE=1 and flushE=1 together -> E cleared; stallM=1 with branchM=1 for 2 cycles -> M regs and counters unchanged; flushM with branchE=1 -> branchM=0 and no count.
- Saturation: preload via 2^CNT_WIDTH retirements with CNT_WIDTH=4, i.e. 16 retired mispredicts -> branch_cnt=mispred_cnt=0xF, with no wrap to 0.
